debounce_scheduler: RTL and testbench

- Conditions N asynchronous level inputs (buttons, straps, slow status pins) for the core clock domain.
- Each channel passes through an internal synchronization chain, then a per-channel debounce filter timed by a shared prescaler.
- Debounced edges become events, served one at a time by a round-robin arbiter onto a single valid/ready event stream.
- Sits between board-level IO pins and the control logic that consumes input events.

---
 rtl/debounce_scheduler.sv | 124 ++++++++++++
 tb/tb_debounce_scheduler.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/debounce_scheduler.sv
// debounce_scheduler: sync + debounce N inputs, round-robin edge events on valid/ready (DEBOUNCE_SCHEDULER_TIMESTAMP_EN adds owv_evt_time)
module debounce_scheduler #(
    parameter int p_CHANNELS = 4,
    parameter int p_SYNC_DEPTH = 2,
    parameter int p_PRESCALE = 1000,
    parameter int p_STABLE_TICKS = 8,
    parameter logic [p_CHANNELS-1:0] p_INIT_VALUE = '0,
    localparam int CW = p_CHANNELS > 1 ? $clog2(p_CHANNELS) : 1
) (
    input logic iw_clk,
    input logic iw_reset,
    input logic [p_CHANNELS-1:0] iwv_raw,
    output logic [p_CHANNELS-1:0] owv_level,
    output logic ow_evt_valid,
    input logic iw_evt_ready,
    output logic [CW-1:0] owv_evt_channel,
    output logic ow_evt_rising,
`ifdef DEBOUNCE_SCHEDULER_TIMESTAMP_EN
    output logic [15:0] owv_evt_time,
`endif
    output logic [p_CHANNELS-1:0] owv_overflow,
    input logic iw_ovf_clear
);
    localparam int PW = $clog2(p_PRESCALE);
    localparam int SW = p_STABLE_TICKS > 1 ? $clog2(p_STABLE_TICKS) : 1;
    typedef enum logic {IDLE, OFFER} state_t;
    state_t state, state_n;
    logic [p_CHANNELS-1:0] sync_q [p_SYNC_DEPTH];
    logic [PW-1:0] pre_cnt;
    logic [SW-1:0] stab_cnt [p_CHANNELS];
    logic [p_CHANNELS-1:0] synced, toggle, take, pending, dir;
    logic [CW-1:0] ptr, sel;
    logic tick, load;
    assign synced = sync_q[p_SYNC_DEPTH-1];
    assign tick = pre_cnt == PW'(p_PRESCALE - 1);
    assign ow_evt_valid = state == OFFER;
    // synchronizer shift chain per channel
    always_ff @(posedge iw_clk) begin
        if (iw_reset) begin
            for (int i = 0; i < p_SYNC_DEPTH; i++) sync_q[i] <= p_INIT_VALUE;
        end else begin
            sync_q[0] <= iwv_raw;
            for (int i = 1; i < p_SYNC_DEPTH; i++) sync_q[i] <= sync_q[i-1];
        end
    end
    // free-running prescaler producing the sample tick
    always_ff @(posedge iw_clk) pre_cnt <= iw_reset || tick ? '0 : pre_cnt + 1'b1;
    // a channel toggles on the tick that completes its stability window
    always_comb begin
        toggle = '0;
        for (int i = 0; i < p_CHANNELS; i++)
            toggle[i] = tick && synced[i] != owv_level[i] && stab_cnt[i] == SW'(p_STABLE_TICKS - 1);
    end
    // stability counters and debounced levels
    always_ff @(posedge iw_clk) begin
        if (iw_reset) begin
            owv_level <= p_INIT_VALUE;
            for (int i = 0; i < p_CHANNELS; i++) stab_cnt[i] <= '0;
        end else if (tick) begin
            owv_level <= owv_level ^ toggle;
            for (int i = 0; i < p_CHANNELS; i++)
                stab_cnt[i] <= synced[i] == owv_level[i] || toggle[i] ? '0 : stab_cnt[i] + 1'b1;
        end
    end
    // first pending channel at or after the round-robin pointer
    always_comb begin
        sel = '0;
        for (int k = p_CHANNELS - 1; k >= 0; k--)
            if (pending[(int'(ptr) + k) % p_CHANNELS]) sel = CW'((int'(ptr) + k) % p_CHANNELS);
    end
    // event FSM: load a new event when idle or on handshake
    always_comb begin
        state_n = state;
        load = 1'b0;
        take = '0;
        if (state == IDLE || iw_evt_ready) begin
            load = |pending;
            state_n = |pending ? OFFER : IDLE;
        end
        for (int i = 0; i < p_CHANNELS; i++) take[i] = load && sel == CW'(i);
    end
    // event FSM state register
    always_ff @(posedge iw_clk) state <= iw_reset ? IDLE : state_n;
    // pending/dir/overflow; a new toggle beats the arbiter's clear
    always_ff @(posedge iw_clk) begin
        if (iw_reset) begin
            pending <= '0;
            dir <= '0;
            owv_overflow <= '0;
        end else begin
            pending <= (pending & ~take) | toggle;
            dir <= (dir & ~toggle) | (synced & toggle);
            owv_overflow <= (owv_overflow & ~{p_CHANNELS{iw_ovf_clear}}) | (toggle & pending & ~take);
        end
    end
    // offered event registers and round-robin pointer
    always_ff @(posedge iw_clk) begin
        if (iw_reset) begin
            ptr <= '0;
            owv_evt_channel <= '0;
            ow_evt_rising <= 1'b0;
        end else if (load) begin
            owv_evt_channel <= sel;
            ow_evt_rising <= dir[sel];
            ptr <= sel == CW'(p_CHANNELS - 1) ? '0 : sel + 1'b1;
        end
    end
`ifdef DEBOUNCE_SCHEDULER_TIMESTAMP_EN
    logic [15:0] ts_cnt;
    logic [15:0] ts_q [p_CHANNELS];
    // tick counter, per-channel capture at toggle, output on load
    always_ff @(posedge iw_clk) begin
        if (iw_reset) begin
            ts_cnt <= '0;
            owv_evt_time <= '0;
            for (int i = 0; i < p_CHANNELS; i++) ts_q[i] <= '0;
        end else begin
            if (tick) ts_cnt <= ts_cnt + 1'b1;
            for (int i = 0; i < p_CHANNELS; i++) if (toggle[i]) ts_q[i] <= ts_cnt;
            if (load) owv_evt_time <= ts_q[sel];
        end
    end
`endif
endmodule

// File: tb/tb_debounce_scheduler.sv
// tb_debounce_scheduler: directed stimulus, cycle model compare plus literal event checks
module tb_debounce_scheduler;
    localparam int N = 4, SYNC = 2, PRE = 4, STB = 3;
    logic clk = 0, rst = 1, ready = 1, clr = 0;
    logic [N-1:0] raw = '0, level, ovf;
    logic valid, rising;
    logic [1:0] ch;
`ifdef DEBOUNCE_SCHEDULER_TIMESTAMP_EN
    logic [15:0] evt_time;
`endif
    int checks = 0, failures = 0, cyc = 0, valid_cnt = 0, lat, e0, v0;
    int ev_ch[$], ev_rise[$], ev_cyc[$];
    int m_pre, m_cnt [N], m_ptr, m_ch, m_sel;
    logic [N-1:0] m_sync [SYNC];
    logic [N-1:0] m_level, m_pend, m_dir, m_ovf, m_syn, m_tog, m_set;
    logic m_valid, m_rise, m_tick;

    debounce_scheduler #(.p_CHANNELS(N), .p_SYNC_DEPTH(SYNC), .p_PRESCALE(PRE),
        .p_STABLE_TICKS(STB), .p_INIT_VALUE(4'b0000)) dut (
        .iw_clk(clk), .iw_reset(rst), .iwv_raw(raw), .owv_level(level),
        .ow_evt_valid(valid), .iw_evt_ready(ready), .owv_evt_channel(ch),
        .ow_evt_rising(rising),
`ifdef DEBOUNCE_SCHEDULER_TIMESTAMP_EN
        .owv_evt_time(evt_time),
`endif
        .owv_overflow(ovf), .iw_ovf_clear(clr));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // reference model: advances one clock using the pre-edge inputs
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_pre = 0; m_ptr = 0; m_ch = 0; m_rise = 0; m_valid = 0;
            m_level = '0; m_pend = '0; m_dir = '0; m_ovf = '0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            for (int i = 0; i < SYNC; i++) m_sync[i] = '0;
        end else begin
            m_tick = m_pre == PRE - 1;
            m_pre = m_tick ? 0 : m_pre + 1;
            m_syn = m_sync[SYNC-1];
            for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
            m_sync[0] = raw;
            m_tog = '0;
            if (m_tick)
                for (int i = 0; i < N; i++) begin
                    if (m_syn[i] == m_level[i]) m_cnt[i] = 0;
                    else if (m_cnt[i] == STB - 1) begin m_tog[i] = 1; m_cnt[i] = 0; end
                    else m_cnt[i]++;
                end
            if (!m_valid || ready) begin
                m_valid = 0;
                m_sel = -1;
                for (int k = 0; k < N; k++)
                    if (m_sel < 0 && m_pend[(m_ptr + k) % N]) m_sel = (m_ptr + k) % N;
                if (m_sel >= 0) begin
                    m_valid = 1; m_ch = m_sel; m_rise = m_dir[m_sel];
                    m_pend[m_sel] = 0; m_ptr = (m_sel + 1) % N;
                end
            end
            m_set = '0;
            for (int i = 0; i < N; i++)
                if (m_tog[i]) begin
                    m_set[i] = m_pend[i];
                    m_pend[i] = 1; m_dir[i] = m_syn[i]; m_level[i] = m_syn[i];
                end
            if (clr) m_ovf = '0;
            m_ovf = m_ovf | m_set;
        end
    end

    // per-cycle compare against the model, plus handshake logging
    always @(negedge clk) begin
        check("level", level, m_level);
        check("valid", valid, m_valid);
        check("overflow", ovf, m_ovf);
        if (m_valid) begin
            check("channel", ch, m_ch);
            check("rising", rising, m_rise);
        end
        if (valid) valid_cnt++;
        if (valid && ready && !rst) begin
            ev_ch.push_back(ch); ev_rise.push_back(rising); ev_cyc.push_back(cyc);
        end
    end

    initial begin
        cycles(3);
        rst = 0;
        cycles(100);
        check("t1_level", level, 0);
        check("t1_ovf", ovf, 0);
        check("t1_no_valid", valid_cnt, 0);
        check("t1_ch", ch, 0);
        check("t1_rise", rising, 0);
        e0 = ev_ch.size(); v0 = valid_cnt;
        raw[1] = 1; lat = 0;
        while (!level[1] && lat < 40) begin cycles(1); lat++; end
        check("t2_latency_in_11_14", lat >= 11 && lat <= 14, 1);
        cycles(10);
        check("t2_events", ev_ch.size() - e0, 1);
        if (ev_ch.size() > e0) begin
            check("t2_ch", ev_ch[e0], 1);
            check("t2_rise", ev_rise[e0], 1);
        end
        check("t2_valid_cycles", valid_cnt - v0, 1);
        v0 = valid_cnt;
        raw[2] = 1;
        cycles(6);
        raw[2] = 0;
        cycles(30);
        check("t3_level", level, 4'b0010);
        check("t3_no_event", valid_cnt - v0, 0);
        rst = 1; raw = '0;
        cycles(2);
        rst = 0; ready = 0; raw = 4'b1001;
        cycles(40);
        check("t4_offer_valid", valid, 1);
        check("t4_offer_ch", ch, 0);
        check("t4_offer_rise", rising, 1);
        e0 = ev_ch.size();
        ready = 1;
        cycles(5);
        check("t4_events", ev_ch.size() - e0, 2);
        if (ev_ch.size() >= e0 + 2) begin
            check("t4_first_ch", ev_ch[e0], 0);
            check("t4_second_ch", ev_ch[e0+1], 3);
            check("t4_second_rise", ev_rise[e0+1], 1);
            check("t4_back_to_back", ev_cyc[e0+1] - ev_cyc[e0], 1);
        end
        raw = '0;
        cycles(25);
        check("t4_fall_events", ev_ch.size() - e0, 4);
        if (ev_ch.size() >= e0 + 4) begin
            check("t4_fall_first_ch", ev_ch[e0+2], 0);
            check("t4_fall_first_rise", ev_rise[e0+2], 0);
            check("t4_fall_second_ch", ev_ch[e0+3], 3);
        end
        ready = 0; raw[2] = 1;
        cycles(20);
        raw[1] = 1;
        cycles(20);
        raw[1] = 0;
        cycles(20);
        check("t5_ovf", ovf, 4'b0010);
        check("t5_level", level, 4'b0100);
        check("t5_offer_ch", ch, 2);
        clr = 1;
        cycles(1);
        clr = 0;
        check("t5_ovf_clear", ovf, 0);
        e0 = ev_ch.size();
        ready = 1;
        cycles(10);
        check("t5_events", ev_ch.size() - e0, 2);
        if (ev_ch.size() >= e0 + 2) begin
            check("t5_ev0_ch", ev_ch[e0], 2);
            check("t5_ev1_ch", ev_ch[e0+1], 1);
            check("t5_ev1_rise", ev_rise[e0+1], 0);
        end
        ready = 0; raw[0] = 1;
        cycles(20);
        check("t6_offer_valid", valid, 1);
        rst = 1; raw = '0;
        cycles(1);
        check("t6_valid", valid, 0);
        check("t6_level", level, 0);
        check("t6_ch", ch, 0);
        check("t6_rise", rising, 0);
        rst = 0; ready = 1; v0 = valid_cnt;
        cycles(50);
        check("t6_no_event", valid_cnt - v0, 0);
        check("t6_level_after", level, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
